// File: rtl/fir_out_decimator.sv
// rtl/fir_out_decimator.sv - integrate-and-dump decimator with round/shift/saturate and output FIFO
module fir_out_decimator #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int DECIM = 4,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  y_in,
  input  logic                    y_valid,
  output logic signed [OUT_W-1:0] d_out,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic                    sat_pulse,
  output logic                    ovf,
  output logic [7:0]              drop_cnt
);

  localparam int ACC_W = IN_W + $clog2(DECIM);
  localparam int PH_W  = $clog2(DECIM);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [OUT_W-1:0]        mem_q [DEPTH];
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              drop_q, drop_d;

  logic signed [ACC_W-1:0] y_ext, sum;
  logic signed [ACC_W:0]   rounded, shifted;
  logic [OUT_W-1:0]        result;
  logic                    clamped, push, do_push, do_pop, full;

  assign y_ext = {{(ACC_W-IN_W){y_in[IN_W-1]}}, y_in};
  assign sum   = acc_q + y_ext;

  // One guard bit above the accumulator absorbs the rounding offset.
  always_comb begin
    rounded = $signed({sum[ACC_W-1], sum}) + HALF;
    shifted = rounded >>> SHIFT;
    clamped = 1'b0;
    result  = shifted[OUT_W-1:0];
    if (shifted > MAXV) begin
      result  = MAXV[OUT_W-1:0];
      clamped = 1'b1;
    end else if (shifted < MINV) begin
      result  = MINV[OUT_W-1:0];
      clamped = 1'b1;
    end
  end

  assign push    = y_valid && (phase_q == PH_W'(DECIM - 1));
  assign full    = (cnt_q == CW'(DEPTH));
  assign d_valid = (cnt_q != '0);
  assign do_pop  = d_valid && d_ready;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    sat_d   = push && clamped;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (y_valid) begin
      if (push) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + 1'b1;
      end
    end
    if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    if (push && !do_push) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      phase_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage needs no reset: the occupancy count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_q] <= result;
  end

  assign d_out     = d_valid ? $signed(mem_q[rd_q]) : '0;
  assign sat_pulse = sat_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// tb/tb_fir_out_decimator.sv - randomized and directed bench against a queue-based reference model
module tb_fir_out_decimator;
  localparam int IN_W = 16, OUT_W = 8, DECIM = 4, SHIFT = 2, DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [IN_W-1:0]  y_in;
  logic                    y_valid;
  logic signed [OUT_W-1:0] d_out;
  logic                    d_valid;
  logic                    d_ready;
  logic                    sat_pulse;
  logic                    ovf;
  logic [7:0]              drop_cnt;

  fir_out_decimator #(.IN_W(IN_W), .OUT_W(OUT_W), .DECIM(DECIM), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .d_out(d_out), .d_valid(d_valid),
    .d_ready(d_ready), .sat_pulse(sat_pulse), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_phase, m_acc, m_drops;
  bit m_ovf, m_sat;
  int m_fifo[$];

  task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_result(input int sum, output bit sat);
    int div, t, r, hi, lo;
    div = 1 << SHIFT;
    hi  = (1 << (OUT_W - 1)) - 1;
    lo  = -(1 << (OUT_W - 1));
    t   = sum + div / 2;
    r   = (t >= 0) ? t / div : -((-t + div - 1) / div);
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    return r;
  endfunction

  task automatic model_edge(input bit r, input bit v, input int y, input bit rdy);
    bit pop, push, s;
    int res;
    if (r) begin
      m_phase = 0; m_acc = 0; m_drops = 0; m_ovf = 0; m_sat = 0;
      m_fifo.delete();
      return;
    end
    pop  = (m_fifo.size() > 0) && rdy;
    push = 0;
    res  = 0;
    m_sat = 0;
    if (v) begin
      if (m_phase < DECIM - 1) begin
        m_acc += y;
        m_phase++;
      end else begin
        res = model_result(m_acc + y, s);
        m_sat = s;
        m_acc = 0;
        m_phase = 0;
        push = 1;
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(res);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input int y, input bit rdy);
    rst = r; y_valid = v; y_in = y[IN_W-1:0]; d_ready = rdy;
    @(posedge clk);
    model_edge(r, v, y, rdy);
    #1;
    check_eq("d_valid", d_valid, (m_fifo.size() > 0) ? 1 : 0);
    check_eq("d_out", d_out, (m_fifo.size() > 0) ? m_fifo[0] : 0);
    check_eq("sat_pulse", sat_pulse, m_sat);
    check_eq("ovf", ovf, m_ovf);
    check_eq("drop_cnt", drop_cnt, m_drops);
  endtask

  initial begin
    int ylist[4];
    int y;
    rst = 1'b1; y_valid = 1'b0; y_in = '0; d_ready = 1'b0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("reset_dout", d_out, 0);
    check_eq("reset_dvalid", d_valid, 0);

    ylist = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) step(0, 1, ylist[i], 1);
    check_eq("t1_dout", d_out, 25);
    check_eq("t1_sat", sat_pulse, 0);
    step(0, 0, 0, 1);
    check_eq("t1_single", d_valid, 0);

    for (int i = 0; i < 4; i++) begin
      step(0, 1, -3, 1);
      step(0, 0, 99, 1);
    end
    check_eq("t2_dout", d_out, 0);
    for (int i = 0; i < 3; i++) step(0, 1, -3, 0);
    step(0, 0, 77, 0);
    step(0, 1, -3, 0);
    check_eq("t2_dout_gap", d_out, -3);
    step(0, 0, 0, 1);

    for (int i = 0; i < 4; i++) step(0, 1, 1000, 0);
    check_eq("t3_pos", d_out, 127);
    check_eq("t3_pos_sat", sat_pulse, 1);
    for (int i = 0; i < 4; i++) step(0, 1, -1000, (i == 0));
    check_eq("t3_neg", d_out, -128);
    check_eq("t3_neg_sat", sat_pulse, 1);
    step(0, 0, 0, 1);

    for (int i = 0; i < 20; i++) step(0, 1, 4, 0);
    check_eq("t4_ovf", ovf, 1);
    check_eq("t4_drops", drop_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_drain", d_out, 4);
      step(0, 0, 0, 1);
    end
    check_eq("t4_empty", d_valid, 0);

    for (int i = 0; i < 16; i++) step(0, 1, 4, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8, 0);
    step(0, 1, 8, 1);
    check_eq("t5_drops", drop_cnt, 1);
    check_eq("t5_occ", m_fifo.size(), 4);
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_order", d_out, 4);
      step(0, 0, 0, 1);
    end
    check_eq("t5_last", d_out, 8);
    step(0, 0, 0, 1);

    step(0, 1, 50, 0);
    step(0, 1, 50, 0);
    step(1, 1, 50, 0);
    check_eq("t6_rst_ovf", ovf, 0);
    check_eq("t6_rst_drops", drop_cnt, 0);
    check_eq("t6_rst_valid", d_valid, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8, 1);
    check_eq("t6_dout", d_out, 8);
    step(0, 0, 0, 1);
    check_eq("t6_single", d_valid, 0);

    for (int i = 0; i < 4 * (DEPTH + 260); i++) step(0, 1, $urandom_range(0, 40), 0);
    check_eq("drop_sat", drop_cnt, 255);
    step(1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) y = int'($signed(16'($urandom())));
      else y = int'($urandom_range(0, 400)) - 200;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), y, ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
